// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM state
// encoding, default abort timeout and the wait-counter helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Slave-wait cycles tolerated before a transfer is aborted.
    localparam int TIMEOUT_DEFAULT = 255;

    localparam int         CNT_W   = 8;
    localparam logic [7:0] CNT_MAX = 8'hFF;

    // Saturating increment for the slave-wait counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker: a lone request always wins, a tie goes
// to the master named by ptr.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Pure combinational grant selection.
    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_idx = ptr;
        end else begin
            gnt_idx = req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter2.sv
// Two-master arbiter onto one picorv32-style native memory port.
//
// Handshake: a master raises mN_valid with stable instr/addr/wdata/wstrb
// and keeps it high until it sees mN_ready=1 (one-cycle pulse). The
// slave side sees s_valid held with constant payload until it answers
// with s_ready=1 for one cycle, or until the wait count hits TIMEOUT, in
// which case the master gets ready together with err=1 and rdata=0.
// Each transfer goes IDLE -> BUSY -> RESP -> IDLE; RESP is a single
// cycle in which new requests are not looked at.
module mem_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        owner,

    output logic [1:0]  dbg_state_o,
    output logic        dbg_ptr_o
);

    // Abort fires on the wait cycle that brings the count up to TIMEOUT;
    // a TIMEOUT the 8-bit counter cannot reach never aborts.
    localparam bit         TO_EN   = (TIMEOUT > 0) && (TIMEOUT <= 255);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ptr_q;
    logic              owner_q;

    logic              s_valid_q;
    logic              s_instr_q;
    logic [31:0]       s_addr_q;
    logic [31:0]       s_wdata_q;
    logic [3:0]        s_wstrb_q;

    logic [1:0]        m_ready_q;
    logic [1:0]        m_err_q;
    logic [31:0]       m_rdata_q [2];

    logic              gnt_valid;
    logic              gnt_idx;
    logic              load;
    logic              done_ok;
    logic              done_abort;
    logic              timeout_hit;

    rr_pick2 u_pick (
        .req       ({m1_valid, m0_valid}),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    // Next-state logic; s_ready wins over the abort in the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        done_ok    = 1'b0;
        done_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (s_ready) begin
                    done_ok = 1'b1;
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    done_abort = 1'b1;
                    cnt_d      = '0;
                    state_d    = RESP;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slave-side request: latched on grant, frozen for the whole of BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q   <= 1'b0;
            s_valid_q <= 1'b0;
            s_instr_q <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
        end else if (load) begin
            owner_q   <= gnt_idx;
            s_valid_q <= 1'b1;
            s_instr_q <= gnt_idx ? m1_instr : m0_instr;
            s_addr_q  <= gnt_idx ? m1_addr  : m0_addr;
            s_wdata_q <= gnt_idx ? m1_wdata : m0_wdata;
            s_wstrb_q <= gnt_idx ? m1_wstrb : m0_wstrb;
        end else if (done_ok || done_abort) begin
            s_valid_q <= 1'b0;
        end
    end

    // Round-robin pointer: prefer the other master after every finished transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (done_ok || done_abort) begin
            ptr_q <= ~owner_q;
        end
    end

    // Master-side response: one-cycle ready/err pulse, rdata held between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_ready_q    <= '0;
            m_err_q      <= '0;
            m_rdata_q[0] <= '0;
            m_rdata_q[1] <= '0;
        end else begin
            m_ready_q <= '0;
            m_err_q   <= '0;
            if (done_ok) begin
                m_ready_q[owner_q] <= 1'b1;
                m_rdata_q[owner_q] <= s_rdata;
            end else if (done_abort) begin
                m_ready_q[owner_q] <= 1'b1;
                m_err_q[owner_q]   <= 1'b1;
                m_rdata_q[owner_q] <= '0;
            end
        end
    end

    assign s_valid     = s_valid_q;
    assign s_instr     = s_instr_q;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign s_wstrb     = s_wstrb_q;
    assign owner       = owner_q;

    assign m0_ready    = m_ready_q[0];
    assign m1_ready    = m_ready_q[1];
    assign m0_err      = m_err_q[0];
    assign m1_err      = m_err_q[1];
    assign m0_rdata    = m_rdata_q[0];
    assign m1_rdata    = m_rdata_q[1];

    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule
